// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with credit-limited requests, in-order response FIFO and redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count;
    logic [AW-1:0] f_head, f_tail, q_head, q_tail;
    logic [31:0]   f_data [DEPTH];
    logic [31:0]   f_pc   [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic          req_fire, resp_ok, drop, push, pop;

    // Outstanding requests plus buffered words never exceed DEPTH, so responses always find a slot
    assign imem_req_valid = !reset && !redirect_valid && ({1'b0, outstanding} + {1'b0, fifo_count} < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign pc_next        = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_ok        = imem_resp_valid && outstanding != '0;
    assign drop           = resp_ok && (redirect_valid || drop_cnt != '0);
    assign push           = resp_ok && !drop;
    assign inst_valid     = fifo_count != '0;
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    assign inst_data      = inst_valid ? f_data[f_head] : '0;
    assign inst_pc        = inst_valid ? f_pc[f_head] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            f_head      <= '0;
            f_tail      <= '0;
            q_head      <= '0;
            q_tail      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                q_tail   <= q_tail + AW'(1);
            end
            if (resp_ok)
                q_head <= q_head + AW'(1);
            // Every request still in flight after a redirect is stale and must be discarded
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc & ~32'd3;
                drop_cnt   <= outstanding - CW'(resp_ok);
                fifo_count <= '0;
                f_head     <= '0;
                f_tail     <= '0;
            end else begin
                drop_cnt   <= drop_cnt - CW'(drop);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (push)
                    f_tail <= f_tail + AW'(1);
                if (pop)
                    f_head <= f_head + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            q_pc[q_tail] <= fetch_pc;
        if (push) begin
            f_data[f_tail] <= imem_resp_data;
            f_pc[f_tail]   <= q_pc[q_head];
        end
    end

    assert property (@(posedge clk) disable iff (reset) imem_resp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic checked against a queue-based reference model.
module tb_fetch_unit;
  localparam int D = 2;
  localparam logic [31:0] W_RESET = 32'hFFFF_FFF8;
  logic        clk = 0, reset = 1, redirect_valid = 0, imem_req_ready = 0, imem_resp_valid = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, imem_resp_data = 0;
  logic        imem_req_valid, inst_valid, w_req_valid, w_inst_valid;
  logic [31:0] imem_req_addr, inst_data, inst_pc, pc_next, w_req_addr, w_inst_data, w_inst_pc, w_pc_next;
  typedef struct {logic [31:0] pc; bit stale;} fl_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} fe_t;
  typedef struct {logic [31:0] addr; int due;} mr_t;
  fl_t infl[$];
  fe_t fq[$];
  mr_t mq[$];
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  logic [31:0] m_pc = 0, w_off = W_RESET;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc_next(pc_next));

  fetch_unit #(.RESET_PC(W_RESET), .DEPTH(D)) dut_w (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_ready(inst_ready),
    .pc_next(w_pc_next));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic erv, eiv;
    logic [31:0] ed, ep;
    fl_t e;
    imem_resp_valid = mq.size() > 0 && mq[0].due <= cyc;
    imem_resp_data  = imem_resp_valid ? mem_word(mq[0].addr) : $urandom;
    #1;
    erv = !redirect_valid && (infl.size() + fq.size() < D);
    eiv = fq.size() != 0;
    ed  = eiv ? fq[0].data : 32'h0;
    ep  = eiv ? fq[0].pc : 32'h0;
    chk("req_valid", imem_req_valid, erv);
    chk("req_addr", imem_req_addr, m_pc);
    chk("pc_next", pc_next, m_pc);
    chk("inst_valid", inst_valid, eiv);
    chk("inst_data", inst_data, ed);
    chk("inst_pc", inst_pc, ep);
    chk("w_req_valid", w_req_valid, erv);
    chk("w_req_addr", w_req_addr, m_pc + w_off);
    if (imem_resp_valid)
      void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready)
      mq.push_back('{imem_req_addr, cyc + lat});
    if (eiv && inst_ready && !redirect_valid)
      void'(fq.pop_front());
    if (imem_resp_valid && infl.size() > 0) begin
      e = infl.pop_front();
      if (!e.stale && !redirect_valid)
        fq.push_back('{e.pc, mem_word(e.pc)});
    end
    if (redirect_valid) begin
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1;
      m_pc  = redirect_pc & ~32'd3;
      w_off = 32'h0;
    end
    if (erv && imem_req_ready) begin
      infl.push_back('{m_pc, 1'b0});
      m_pc += 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1;
    imem_resp_valid = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_w_req_addr", w_req_addr, W_RESET);
    mq.delete();
    infl.delete();
    fq.delete();
    m_pc  = 32'h0;
    w_off = W_RESET;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    lat = 1; imem_req_ready = 1; inst_ready = 1;
    repeat (10) cycle();
    do_reset();
    inst_ready = 0;
    repeat (6) cycle();
    inst_ready = 1;
    cycle();
    inst_ready = 0;
    repeat (4) cycle();
    do_reset();
    lat = 3; inst_ready = 1;
    repeat (2) cycle();
    redirect_valid = 1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 0;
    repeat (10) cycle();
    do_reset();
    lat = 1;
    cycle();
    redirect_valid = 1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect_valid = 0;
    repeat (6) cycle();
    lat = 2;
    repeat (2) cycle();
    redirect_valid = 1; redirect_pc = 32'h0000_0400;
    cycle();
    redirect_pc = 32'h0000_0800;
    cycle();
    redirect_valid = 0;
    repeat (8) cycle();
    inst_ready = 0; lat = 1;
    repeat (6) cycle();
    do_reset();
    inst_ready = 1;
    repeat (4) cycle();
    for (int n = 0; n < 600; n++) begin
      redirect_valid = $urandom_range(0, 99) < 8;
      redirect_pc    = $urandom;
      imem_req_ready = $urandom_range(0, 3) != 0;
      inst_ready     = $urandom_range(0, 2) != 0;
      lat            = $urandom_range(1, 4);
      cycle();
    end
    redirect_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
